fetch_stage: RTL and testbench

- Program-counter and fetch-buffer stage that sits directly upstream of the instruction memory.
- Drives `prog_counter` into the memory and captures the returned 32-bit `instruction` into an IF/ID holding register.
- Hands the captured instruction to decode through a valid/ready handshake.
- Accepts branch redirects from execute, flushes wrong-path instructions, and signals completion when the PC runs past the end of the program.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/sat_counter.sv | 21 ++
 rtl/fetch_stage.sv | 118 +++++++++++
 tb/tb_fetch_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage and its neighbours.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PC_W_DEF     = 4;
  localparam int PROG_LEN_DEF = 11;
  localparam int CNT_W_DEF    = 8;

  // Branch opcodes, consumed by execute and by test stimulus.
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

endpackage

// File: rtl/sat_counter.sv
// Generic up-counter that sticks at its all-ones value.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count enabled events, holding once the maximum value is reached.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                       r_count <= '0;
    else if (i_inc && (r_count != '1))  r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// PC generation and IF/ID holding register with branch redirect/flush.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int PROG_LEN = PROG_LEN_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [PC_W-1:0]  prog_counter,
  input  logic [31:0]      instruction,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [PC_W-1:0]  if_pc,
  input  logic             id_ready,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_pc,
  input  logic [15:0]      br_offset,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] handoff_cnt
);

  // One extra PC bit so the PC can step to PROG_LEN without wrapping.
  state_t          r_state;
  logic [PC_W:0]   r_pc;
  logic            r_valid;
  logic [31:0]     r_instr;
  logic [PC_W-1:0] r_if_pc;

  logic            w_active;
  logic            w_redirect;
  logic            w_handoff;
  logic            w_load;
  logic            w_last;
  logic [PC_W:0]   w_pc_next;
  logic [17:0]     w_target;
  logic            w_in_range;

  assign w_active   = (r_state == FETCH) || (r_state == DRAIN);
  assign w_redirect = br_taken && w_active;
  // A flushed entry is never counted as handed off.
  assign w_handoff  = r_valid && id_ready && !w_redirect;
  assign w_load     = (!r_valid || id_ready) && (r_state == FETCH) && !br_taken;
  assign w_pc_next  = r_pc + 1'b1;
  assign w_last     = (r_pc == (PC_W+1)'(PROG_LEN - 1));

  // Two's-complement target with headroom; bit 17 set means negative.
  assign w_target   = {{(18-PC_W){1'b0}}, br_pc} + 18'd1
                    + {{2{br_offset[15]}}, br_offset};
  assign w_in_range = !w_target[17] && (w_target < 18'(PROG_LEN));

  // Fetch FSM: redirect beats load/stall; DRAIN waits for the last handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_valid <= 1'b0;
      r_instr <= '0;
      r_if_pc <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= FETCH;
            r_pc    <= '0;
          end
        end
        DONE: begin
          if (start) begin
            r_state <= FETCH;
            r_pc    <= '0;
            r_valid <= 1'b0;
          end
        end
        default: begin
          if (br_taken) begin
            r_valid <= 1'b0;
            if (w_in_range) begin
              r_pc    <= {1'b0, w_target[PC_W-1:0]};
              r_state <= FETCH;
            end else begin
              r_state <= DONE;
            end
          end else if (r_state == FETCH) begin
            if (w_load) begin
              r_instr <= instruction;
              r_if_pc <= r_pc[PC_W-1:0];
              r_valid <= 1'b1;
              r_pc    <= w_pc_next;
              if (w_last) r_state <= DRAIN;
            end
          end else if (!r_valid || id_ready) begin
            r_valid <= 1'b0;
            r_state <= DONE;
          end
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_handoff_cnt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_inc   (w_handoff),
    .o_count (handoff_cnt)
  );

  assign prog_counter = r_pc[PC_W-1:0];
  assign if_valid     = r_valid;
  assign if_instr     = r_instr;
  assign if_pc        = r_if_pc;
  assign busy         = w_active;
  assign done         = (r_state == DONE);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues expected handoffs,
// a negedge monitor pops and compares them as decode accepts entries.
module tb_fetch_stage;

  localparam int PC_W = 4;
  localparam int PROG_LEN = 11;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [PC_W-1:0]  prog_counter;
  logic [31:0]      instruction;
  logic             if_valid;
  logic [31:0]      if_instr;
  logic [PC_W-1:0]  if_pc;
  logic             id_ready;
  logic             br_taken;
  logic [PC_W-1:0]  br_pc;
  logic [15:0]      br_offset;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] handoff_cnt;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  fetch_stage #(.PC_W(PC_W), .PROG_LEN(PROG_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_counter(prog_counter),
    .instruction(instruction), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .id_ready(id_ready), .br_taken(br_taken), .br_pc(br_pc),
    .br_offset(br_offset), .busy(busy), .done(done), .handoff_cnt(handoff_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory: distinct word per index, poison beyond the program.
  function automatic logic [31:0] memword(input logic [PC_W-1:0] a);
    if (a >= PROG_LEN) return 32'hDEAD_BEEF;
    return 32'hA500_0000 + {28'd0, a} * 32'h0001_0101;
  endfunction

  assign instruction = memword(prog_counter);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int lo, input int hi);
    exp_t e;
    for (int p = lo; p <= hi; p++) begin
      e.pc    = PC_W'(p);
      e.instr = memword(PC_W'(p));
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_pc(input int p, input int limit);
    int n = 0;
    while (!(if_valid && if_pc == PC_W'(p)) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) chk("wait_pc_timeout", 32'(n), 32'(p));
  endtask

  task automatic run_until_done(input int limit);
    int n = 0;
    while (!done && n < limit) begin
      step();
      n++;
    end
    chk("done_reached", {31'd0, done}, 32'd1);
  endtask

  // Monitor: every accepted, non-flushed entry must match the queue head.
  always @(negedge clk) begin
    if (rst_n && if_valid && id_ready && !br_taken) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_handoff_pc", {28'd0, if_pc}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("handoff_pc", {28'd0, if_pc}, {28'd0, e.pc});
        chk("handoff_instr", if_instr, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; id_ready = 1'b1;
    br_taken = 1'b0; br_pc = '0; br_offset = '0;
    #12;
    chk("rst_pc", {28'd0, prog_counter}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_if_pc", {28'd0, if_pc}, 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_cnt", {24'd0, handoff_cnt}, 32'd0);
    rst_n = 1'b1;
    step();

    // A: straight-line run, plus a start pulse mid-run that must be ignored.
    push_range(0, 10);
    do_start();
    chk("a_busy", {31'd0, busy}, 32'd1);
    step(); step(); step();
    do_start();
    run_until_done(40);
    chk("a_cnt", {24'd0, handoff_cnt}, 32'd11);
    chk("a_q_empty", 32'(exp_q.size()), 32'd0);
    chk("a_busy_end", {31'd0, busy}, 32'd0);

    // B: backpressure while holding pc 4; restart from DONE accumulates.
    push_range(0, 10);
    do_start();
    wait_pc(4, 20);
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("b_stall_if_pc", {28'd0, if_pc}, 32'd4);
      chk("b_stall_instr", if_instr, memword(4'd4));
      chk("b_stall_prog_counter", {28'd0, prog_counter}, 32'd5);
    end
    id_ready = 1'b1;
    step();
    chk("b_release_if_pc", {28'd0, if_pc}, 32'd5);
    run_until_done(40);
    chk("b_cnt", {24'd0, handoff_cnt}, 32'd22);

    // C: forward branch at pc 6 with target 12, out of range.
    push_range(0, 5);
    do_start();
    wait_pc(6, 20);
    br_taken = 1'b1; br_pc = 4'd6; br_offset = 16'd5;
    step();
    br_taken = 1'b0;
    chk("c_valid", {31'd0, if_valid}, 32'd0);
    chk("c_done", {31'd0, done}, 32'd1);
    chk("c_pc_held", {28'd0, prog_counter}, 32'd7);
    chk("c_cnt", {24'd0, handoff_cnt}, 32'd28);
    chk("c_q_empty", 32'(exp_q.size()), 32'd0);

    // D: backward branch from pc 10 during DRAIN to target 8.
    push_range(0, 9);
    push_range(8, 10);
    do_start();
    wait_pc(10, 20);
    br_taken = 1'b1; br_pc = 4'd10; br_offset = 16'hFFFD;
    step();
    br_taken = 1'b0;
    chk("d_pc_target", {28'd0, prog_counter}, 32'd8);
    chk("d_valid", {31'd0, if_valid}, 32'd0);
    chk("d_busy", {31'd0, busy}, 32'd1);
    run_until_done(40);
    chk("d_cnt", {24'd0, handoff_cnt}, 32'd41);
    chk("d_q_empty", 32'(exp_q.size()), 32'd0);

    // E: branch coincides with id_ready on a valid entry: flush, no count.
    push_range(0, 2);
    push_range(6, 10);
    do_start();
    wait_pc(3, 20);
    br_taken = 1'b1; br_pc = 4'd3; br_offset = 16'd2;
    step();
    br_taken = 1'b0;
    chk("e_valid", {31'd0, if_valid}, 32'd0);
    chk("e_pc_target", {28'd0, prog_counter}, 32'd6);
    chk("e_cnt", {24'd0, handoff_cnt}, 32'd44);
    run_until_done(40);
    chk("e_cnt_end", {24'd0, handoff_cnt}, 32'd49);

    // F: async reset mid-run at if_pc 5, then refetch from 0.
    push_range(0, 4);
    do_start();
    wait_pc(5, 20);
    rst_n = 1'b0;
    #1;
    chk("f_rst_pc", {28'd0, prog_counter}, 32'd0);
    chk("f_rst_valid", {31'd0, if_valid}, 32'd0);
    chk("f_rst_instr", if_instr, 32'd0);
    chk("f_rst_if_pc", {28'd0, if_pc}, 32'd0);
    chk("f_rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("f_rst_cnt", {24'd0, handoff_cnt}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    push_range(0, 10);
    do_start();
    run_until_done(40);
    chk("f_cnt", {24'd0, handoff_cnt}, 32'd11);
    push_range(0, 10);
    do_start();
    run_until_done(40);
    chk("f_cnt_accum", {24'd0, handoff_cnt}, 32'd22);

    // G: 22 more runs push the counter past 255; it must saturate.
    for (int r = 0; r < 22; r++) begin
      push_range(0, 10);
      do_start();
      run_until_done(40);
    end
    chk("g_cnt_sat", {24'd0, handoff_cnt}, 32'd255);
    chk("g_q_empty", 32'(exp_q.size()), 32'd0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
